// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_systolic_array matrix multiplier.
//   state_t   : controller states (LOAD, COMP, OUT)
//   comp_len  : number of compute cycles for an X x N by N x Y product
//   cnt_width : bit width needed for a counter that reaches max_val
// Optional build macro used by the datapath: RSA_SATURATE_EN.
package rsa_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        COMP = 2'd1,
        OUT  = 2'd2
    } state_t;

    // The last operand pair meets in PE(X-1,Y-1) at cycle (X-1)+(Y-1)+(N-1).
    function automatic int comp_len(input int x, input int y, input int n);
        return x + y + n - 32'sd2;
    endfunction

    // Width of a counter that must hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
    endfunction

endpackage

// File: rtl/rsa_pe.sv
// One multiply-accumulate cell of the output-stationary systolic array.
// Operands enter on a_in/b_in, are registered to a_out/b_out for the
// right/lower neighbour, and their product is added into acc while en=1.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              accumulate this cycle (array is computing)
//   clr             clear accumulator and operand pipeline
//   a_in, b_in      operands from left / top neighbour (or skew feeder)
//   a_out, b_out    registered operands to right / lower neighbour
//   acc             accumulated result
// Build macro: RSA_SATURATE_EN clamps product and sum to the all-ones value
// instead of wrapping.
module rsa_pe #(
    parameter int IN_LEN  = 4,
    parameter int OUT_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [IN_LEN-1:0]  a_in,
    input  logic [IN_LEN-1:0]  b_in,
    output logic [IN_LEN-1:0]  a_out,
    output logic [IN_LEN-1:0]  b_out,
    output logic [OUT_LEN-1:0] acc
);

    localparam int PW = 2 * IN_LEN;
    // One spare bit above the wider of product/accumulator catches overflow.
    localparam int WW = ((PW > OUT_LEN) ? PW : OUT_LEN) + 1;
    localparam logic [WW-1:0] MAX_W = WW'({OUT_LEN{1'b1}});

    logic [PW-1:0]      prod_s;
    logic [WW-1:0]      prod_w_s;
    logic [OUT_LEN-1:0] acc_nxt_s;
`ifdef RSA_SATURATE_EN
    logic [WW-1:0]      sum_s;
`endif

    // Next accumulator value: wrap-around or saturating MAC.
    always_comb begin
        prod_s = PW'(a_in) * PW'(b_in);
`ifdef RSA_SATURATE_EN
        prod_w_s  = (WW'(prod_s) > MAX_W) ? MAX_W : WW'(prod_s);
        sum_s     = WW'(acc) + prod_w_s;
        acc_nxt_s = (sum_s > MAX_W) ? {OUT_LEN{1'b1}} : sum_s[OUT_LEN-1:0];
`else
        prod_w_s  = WW'(prod_s);
        acc_nxt_s = OUT_LEN'(WW'(acc) + prod_w_s);
`endif
    end

    // Operand shift registers and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (en) begin
                acc <= acc_nxt_s;
            end else begin
                acc <= acc;
            end
        end
    end

endmodule

// File: rtl/rsa_systolic_array.sv
// Output-stationary systolic matrix multiplier C[X][Y] = A[X][N] * B[N][Y].
// A and B arrive as independent row-major word streams, are buffered, then
// skew-fed into an X-by-Y grid of rsa_pe cells. C leaves row-major, one word
// per cycle, on registered outputs.
// Ports:
//   clk                  single rising-edge clock
//   sys_rst              asynchronous active-high reset
//   Xin_val, Xin_data    A stream (row-major)
//   Yin_val, Yin_data    B stream (row-major)
//   out_val, out_data    C stream (row-major), no backpressure
// Build macro: RSA_SATURATE_EN selects saturating arithmetic in every PE.
module rsa_systolic_array
    import rsa_pkg::*;
#(
    parameter int X          = 3,
    parameter int N          = 3,
    parameter int Y          = 3,
    parameter int IN_LEN     = 4,
    parameter int OUT_LEN    = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               Xin_val,
    input  logic [IN_LEN-1:0]  Xin_data,
    input  logic               Yin_val,
    input  logic [IN_LEN-1:0]  Yin_data,
    output logic               out_val,
    output logic [OUT_LEN-1:0] out_data
);

    localparam int COMP_LEN = comp_len(X, Y, N);
    localparam int CCW      = cnt_width(COMP_LEN - 32'sd1);
    localparam int OCW      = cnt_width(X * Y - 32'sd1);

    localparam logic [CCW-1:0]        COMP_LAST  = CCW'(COMP_LEN - 32'sd1);
    localparam logic [OCW-1:0]        OUT_LAST   = OCW'(X * Y - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW_LAST = ADDR_WIDTH'(X - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] A_COL_LAST = ADDR_WIDTH'(N - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] B_ROW_LAST = ADDR_WIDTH'(N - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] B_COL_LAST = ADDR_WIDTH'(Y - 32'sd1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(32'sd1);

    state_t              state_r;
    logic [CCW-1:0]      comp_cnt_r;
    logic [OCW-1:0]      out_idx_r;

    logic [IN_LEN-1:0]   a_buf_r [X][N];
    logic [IN_LEN-1:0]   b_buf_r [N][Y];
    logic [ADDR_WIDTH-1:0] a_row_r, a_col_r, b_row_r, b_col_r;
    logic                a_done_r, b_done_r;

    logic                start_s;
    logic                job_end_s;
    logic                pe_en_s;

    logic [IN_LEN-1:0]   row_a_s [X];
    logic [IN_LEN-1:0]   col_b_s [Y];
    logic [IN_LEN-1:0]   a_link_s [X][Y+1];
    logic [IN_LEN-1:0]   b_link_s [X+1][Y];
    logic [OUT_LEN-1:0]  acc_s [X*Y];

    assign start_s   = (state_r == LOAD) && a_done_r && b_done_r;
    assign job_end_s = (state_r == OUT) && (out_idx_r == OUT_LAST);
    assign pe_en_s   = (state_r == COMP);

    // Operand stream capture; both buffers drain to zero when a job ends.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst || job_end_s) begin
            for (int i = 0; i < X; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_buf_r[i][k] <= '0;
                end
            end
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < Y; j++) begin
                    b_buf_r[k][j] <= '0;
                end
            end
            a_row_r  <= '0;
            a_col_r  <= '0;
            a_done_r <= 1'b0;
            b_row_r  <= '0;
            b_col_r  <= '0;
            b_done_r <= 1'b0;
        end else begin
            if ((state_r == LOAD) && Xin_val && !a_done_r) begin
                a_buf_r[a_row_r][a_col_r] <= Xin_data;
                if (a_col_r == A_COL_LAST) begin
                    a_col_r <= '0;
                    if (a_row_r == A_ROW_LAST) begin
                        a_row_r  <= '0;
                        a_done_r <= 1'b1;
                    end else begin
                        a_row_r <= a_row_r + ADDR_ONE;
                    end
                end else begin
                    a_col_r <= a_col_r + ADDR_ONE;
                end
            end
            if ((state_r == LOAD) && Yin_val && !b_done_r) begin
                b_buf_r[b_row_r][b_col_r] <= Yin_data;
                if (b_col_r == B_COL_LAST) begin
                    b_col_r <= '0;
                    if (b_row_r == B_ROW_LAST) begin
                        b_row_r  <= '0;
                        b_done_r <= 1'b1;
                    end else begin
                        b_row_r <= b_row_r + ADDR_ONE;
                    end
                end else begin
                    b_col_r <= b_col_r + ADDR_ONE;
                end
            end
        end
    end

    // Skew feeders: row i sees A[i][k] at COMP cycle i+k, column j sees
    // B[k][j] at cycle j+k; the PE pipeline adds the remaining j (or i) delay.
    always_comb begin
        for (int i = 0; i < X; i++) begin
            row_a_s[i] = '0;
            for (int k = 0; k < N; k++) begin
                row_a_s[i] = row_a_s[i] |
                    ((pe_en_s && (int'(comp_cnt_r) == i + k)) ? a_buf_r[i][k] : '0);
            end
        end
        for (int j = 0; j < Y; j++) begin
            col_b_s[j] = '0;
            for (int k = 0; k < N; k++) begin
                col_b_s[j] = col_b_s[j] |
                    ((pe_en_s && (int'(comp_cnt_r) == j + k)) ? b_buf_r[k][j] : '0);
            end
        end
    end

    for (genvar gi = 0; gi < X; gi++) begin : g_row_feed
        assign a_link_s[gi][0] = row_a_s[gi];
    end
    for (genvar gj = 0; gj < Y; gj++) begin : g_col_feed
        assign b_link_s[0][gj] = col_b_s[gj];
    end

    for (genvar gi = 0; gi < X; gi++) begin : g_pe_row
        for (genvar gj = 0; gj < Y; gj++) begin : g_pe_col
            rsa_pe #(
                .IN_LEN  (IN_LEN),
                .OUT_LEN (OUT_LEN)
            ) u_pe (
                .clk   (clk),
                .rst   (sys_rst),
                .en    (pe_en_s),
                .clr   (start_s),
                .a_in  (a_link_s[gi][gj]),
                .b_in  (b_link_s[gi][gj]),
                .a_out (a_link_s[gi][gj+1]),
                .b_out (b_link_s[gi+1][gj]),
                .acc   (acc_s[gi*Y+gj])
            );
        end
    end

    // Controller FSM with registered C stream. The first word is launched on
    // the same edge that leaves COMP; row-major order means each word is read
    // only after its PE has finished accumulating.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= LOAD;
            comp_cnt_r <= '0;
            out_idx_r  <= '0;
            out_val    <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state_r)
                LOAD: begin
                    comp_cnt_r <= '0;
                    if (start_s) begin
                        state_r <= COMP;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                COMP: begin
                    if (comp_cnt_r == COMP_LAST) begin
                        state_r   <= OUT;
                        out_idx_r <= '0;
                        out_val   <= 1'b1;
                        out_data  <= acc_s[0];
                    end else begin
                        comp_cnt_r <= comp_cnt_r + CCW'(32'sd1);
                    end
                end
                OUT: begin
                    if (out_idx_r == OUT_LAST) begin
                        state_r    <= LOAD;
                        out_idx_r  <= '0;
                        comp_cnt_r <= '0;
                        out_val    <= 1'b0;
                    end else begin
                        out_idx_r <= out_idx_r + OCW'(32'sd1);
                        out_data  <= acc_s[out_idx_r + OCW'(32'sd1)];
                    end
                end
                default: begin
                    state_r    <= LOAD;
                    comp_cnt_r <= '0;
                    out_idx_r  <= '0;
                    out_val    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_systolic_array.sv
// Self-checking bench for rsa_systolic_array (default 3x3x3, 4-bit in,
// 8-bit out). Expected C words and output latency come from a plain
// arithmetic matrix-product model; honours RSA_SATURATE_EN when defined.
module tb_rsa_systolic_array;

    logic       clk;
    logic       sys_rst;
    logic       Xin_val;
    logic [3:0] Xin_data;
    logic       Yin_val;
    logic [3:0] Yin_data;
    logic       out_val;
    logic [7:0] out_data;

    int total;
    int bad;
    int cyc;
    int a_done_cyc;
    int b_done_cyc;
    int a_m [9];
    int b_m [9];
    int exp_c [9];

    rsa_systolic_array dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .Xin_val  (Xin_val),
        .Xin_data (Xin_data),
        .Yin_val  (Yin_val),
        .Yin_data (Yin_data),
        .out_val  (out_val),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: C = A*B with wrap (or clamp) on an 8-bit result.
    task automatic compute_ref();
        int acc, p;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int k = 0; k < 3; k++) begin
                    p = a_m[r*3+k] * b_m[k*3+c];
`ifdef RSA_SATURATE_EN
                    if (p > 255) p = 255;
                    acc = acc + p;
                    if (acc > 255) acc = 255;
`else
                    acc = (acc + p) % 256;
`endif
                end
                exp_c[r*3+c] = acc;
            end
        end
    endtask

    // mode 0: both streams with random gaps; 1: B fully before A;
    // 2: both back-to-back, B one cycle late, A carries a_words words.
    task automatic drive_streams(input int mode, input int a_words);
        int ai, bi, n;
        logic xv, yv;
        ai = 0; bi = 0; n = 0;
        while (ai < a_words || bi < 9) begin
            xv = 1'b0;
            yv = 1'b0;
            if (ai < a_words) begin
                case (mode)
                    1: xv = (bi >= 9);
                    2: xv = 1'b1;
                    default: xv = 1'($urandom_range(0, 1));
                endcase
            end
            if (bi < 9) begin
                case (mode)
                    1: yv = 1'b1;
                    2: yv = (n >= 1);
                    default: yv = 1'($urandom_range(0, 1));
                endcase
            end
            Xin_val  = xv;
            Xin_data = xv ? ((ai < 9) ? 4'(a_m[ai]) : 4'(ai + 1)) : 4'($urandom);
            Yin_val  = yv;
            Yin_data = yv ? 4'(b_m[bi]) : 4'($urandom);
            @(posedge clk); #1;
            if (xv) begin
                ai++;
                if (ai == 9) a_done_cyc = cyc;
            end
            if (yv) begin
                bi++;
                if (bi == 9) b_done_cyc = cyc;
            end
            n++;
        end
        Xin_val = 1'b0;
        Yin_val = 1'b0;
    endtask

    task automatic watch_output(input string tag);
        int first, last;
        logic seen;
        seen = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(posedge clk); #1;
            if (out_val) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, int'(seen), 1);
        if (seen) begin
            first = cyc;
            last  = (a_done_cyc > b_done_cyc) ? a_done_cyc : b_done_cyc;
            chk({tag, "_latency"}, first - last, 8);
            for (int i = 0; i < 9; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                chk({tag, "_val"}, int'(out_val), 1);
                chk({tag, "_data"}, int'(out_data), exp_c[i]);
            end
            @(posedge clk); #1;
            chk({tag, "_val_drop"}, int'(out_val), 0);
            chk({tag, "_data_hold"}, int'(out_data), exp_c[8]);
        end
    endtask

    task automatic run_job(input string tag, input int mode, input int a_words);
        compute_ref();
        fork
            drive_streams(mode, a_words);
            watch_output(tag);
        join
    endtask

    task automatic set_ident_a();
        for (int i = 0; i < 9; i++) a_m[i] = (i % 4 == 0) ? 1 : 0;
    endtask

    task automatic set_ident_b();
        for (int i = 0; i < 9; i++) b_m[i] = (i % 4 == 0) ? 1 : 0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        a_done_cyc = 0; b_done_cyc = 0;
        sys_rst = 1'b1;
        Xin_val = 1'b0; Xin_data = 4'd0;
        Yin_val = 1'b0; Yin_data = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", int'(out_val), 0);
        chk("rst_data", int'(out_data), 0);
        sys_rst = 1'b0;

        // A = I3, B = 1..9
        set_ident_a();
        for (int i = 0; i < 9; i++) b_m[i] = i + 1;
        run_job("ident", 0, 9);

        // All 15 x all 15
        for (int i = 0; i < 9; i++) begin a_m[i] = 15; b_m[i] = 15; end
        run_job("all15", 0, 9);

        // B loaded completely before A starts
        for (int i = 0; i < 9; i++) a_m[i] = i + 1;
        set_ident_b();
        run_job("b_first", 1, 9);

        // A held valid for 27 words; words past 9 must be ignored
        for (int i = 0; i < 9; i++) a_m[i] = i + 1;
        set_ident_b();
        run_job("overfeed", 2, 27);

        // Reset during OUT after 4 words
        set_ident_a();
        for (int i = 0; i < 9; i++) b_m[i] = i + 1;
        drive_streams(0, 9);
        begin
            int got;
            got = 0;
            for (int w = 0; w < 300; w++) begin
                @(posedge clk); #1;
                if (out_val) begin
                    got = 1;
                    break;
                end
            end
            chk("rst_mid_start", got, 1);
            repeat (3) begin
                @(posedge clk); #1;
            end
            chk("rst_mid_word4", int'(out_data), 4);
            sys_rst = 1'b1;
            #1;
            chk("rst_mid_val", int'(out_val), 0);
            chk("rst_mid_data", int'(out_data), 0);
            @(posedge clk); #1;
            sys_rst = 1'b0;
            repeat (12) begin
                @(posedge clk); #1;
            end
            chk("rst_mid_quiet", int'(out_val), 0);
        end

        // Fresh load after the abort
        for (int i = 0; i < 9; i++) begin a_m[i] = 9 - i; b_m[i] = i + 2; end
        run_job("after_rst", 0, 9);

        // Back-to-back jobs, accumulators must not leak
        for (int i = 0; i < 9; i++) begin a_m[i] = 1; b_m[i] = 1; end
        run_job("b2b_1", 0, 9);
        for (int i = 0; i < 9; i++) begin a_m[i] = 2; b_m[i] = 1; end
        run_job("b2b_2", 0, 9);

        // Random jobs
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 9; i++) begin
                a_m[i] = int'($urandom_range(0, 15));
                b_m[i] = int'($urandom_range(0, 15));
            end
            run_job("rand", j % 2, 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
